// File: rtl/i2s_rx_arbiter_pkg.sv
// Shared types and width helpers for the I2S receive arbiter.
// Arbiter FSM encoding and $clog2-derived index/pointer widths.
package i2s_rx_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int N_CH_DEF       = 16;
  localparam int DATA_W_DEF     = 32;
  localparam int FIFO_DEPTH_DEF = 4;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_rx_chan_fifo.sv
// Per-channel word FIFO holding data plus frame-last flag.
// Simultaneous write and read both land, even when full.
module i2s_rx_chan_fifo
  import i2s_rx_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = idx_w(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [DATA_W:0] mem_q [DEPTH];
  logic [PTR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]  rd_ptr_q, rd_ptr_d;
  logic            do_wr, do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign do_wr = wr_en & (~full | rd_en) & ~flush;
  assign do_rd = rd_en & ~empty;

  assign {rd_last, rd_data} = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[PTR_W-1:0]] <= {wr_last, wr_data};
  end

endmodule

// File: rtl/i2s_rx_arbiter.sv
// Merges N_CH I2S receive streams into one AXI-Stream output,
// round-robin per frame, with a registered output stage.
module i2s_rx_arbiter
  import i2s_rx_arbiter_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [N_CH-1:0]          s_axis_tvalid,
  input  logic [N_CH*DATA_W-1:0]   s_axis_tdata,
  input  logic [N_CH-1:0]          s_axis_tlast,
  input  logic [N_CH-1:0]          i_enable,
  input  logic [4*N_CH-1:0]        i_dst_fpga_index,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic [idx_w(N_CH)-1:0]   m_axis_tid,
  output logic [3:0]               m_axis_tdest,
  output logic [N_CH-1:0]          o_overflow,
  input  logic                     i_overflow_clr
);

  localparam int CH_W = idx_w(N_CH);

  logic [DATA_W-1:0] f_data [N_CH];
  logic [3:0]        dst    [N_CH];
  logic [N_CH-1:0]   f_last, f_empty, f_full, f_rd;
  logic [N_CH-1:0]   avail, ovf_new;
  logic [CH_W-1:0]   sel_ch, rr_ch;
  logic              rr_found, pop, out_rdy;

  arb_state_e        state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [3:0]        dest_q, dest_d, cur_dest;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic [CH_W-1:0]   m_tid_q, m_tid_d;
  logic [3:0]        m_dest_q, m_dest_d;
  logic [N_CH-1:0]   ovf_q, ovf_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign dst[i]     = i_dst_fpga_index[4*i +: 4];
    assign avail[i]   = i_enable[i] & ~f_empty[i];
    assign f_rd[i]    = pop & (sel_ch == CH_W'(i));
    assign ovf_new[i] = s_axis_tvalid[i] & i_enable[i] &
                        f_full[i] & ~f_rd[i];

    // A disabled channel is flushed and held empty.
    i2s_rx_chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .arst_n  (arst_n),
      .flush   (~i_enable[i]),
      .wr_en   (s_axis_tvalid[i] & i_enable[i]),
      .wr_data (s_axis_tdata[DATA_W*i +: DATA_W]),
      .wr_last (s_axis_tlast[i]),
      .rd_en   (f_rd[i]),
      .rd_data (f_data[i]),
      .rd_last (f_last[i]),
      .empty   (f_empty[i]),
      .full    (f_full[i])
    );
  end

  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_ch    = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(last_grant_q) + k) % N_CH;
      if (!rr_found && avail[idx]) begin
        rr_found = 1'b1;
        rr_ch    = CH_W'(idx);
      end
    end
  end

  assign out_rdy = ~m_valid_q | m_axis_tready;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    dest_d       = dest_q;
    sel_ch       = grant_q;
    cur_dest     = dest_q;
    pop          = 1'b0;
    m_valid_d    = m_valid_q & ~m_axis_tready;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    m_tid_d      = m_tid_q;
    m_dest_d     = m_dest_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          sel_ch   = rr_ch;
          grant_d  = rr_ch;
          cur_dest = dst[rr_ch];
          dest_d   = dst[rr_ch];
          state_d  = ST_LOCKED;
          pop      = out_rdy;
        end
      end
      ST_LOCKED: begin
        if (!i_enable[grant_q]) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
        end else begin
          pop = out_rdy & ~f_empty[grant_q];
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) begin
      m_valid_d = 1'b1;
      m_data_d  = f_data[sel_ch];
      m_last_d  = f_last[sel_ch];
      m_tid_d   = sel_ch;
      m_dest_d  = cur_dest;
      if (f_last[sel_ch]) begin
        state_d      = ST_IDLE;
        last_grant_d = sel_ch;
      end
    end
    ovf_d = (i_overflow_clr ? '0 : ovf_q) | ovf_new;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= CH_W'(N_CH - 1);
      dest_q       <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      m_tid_q      <= '0;
      m_dest_q     <= '0;
      ovf_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      dest_q       <= dest_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      m_tid_q      <= m_tid_d;
      m_dest_q     <= m_dest_d;
      ovf_q        <= ovf_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tid    = m_tid_q;
  assign m_axis_tdest  = m_dest_q;
  assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_i2s_rx_arbiter.sv
// Directed self-checking bench for i2s_rx_arbiter.
// Output beats are logged at negedge and checked per scenario.
module tb_i2s_rx_arbiter;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic [15:0]   tvalid = '0;
  logic [511:0]  tdata = '0;
  logic [15:0]   tlast = '0;
  logic [15:0]   en = '1;
  logic [63:0]   dst;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [31:0]   m_data;
  logic          m_last;
  logic [3:0]    m_tid;
  logic [3:0]    m_dest;
  logic [15:0]   ovf;
  logic          ovf_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] q_data [$];
  logic        q_last [$];
  logic [3:0]  q_tid  [$];
  logic [3:0]  q_dest [$];
  int          q_cyc  [$];

  i2s_rx_arbiter dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .s_axis_tvalid    (tvalid),
    .s_axis_tdata     (tdata),
    .s_axis_tlast     (tlast),
    .i_enable         (en),
    .i_dst_fpga_index (dst),
    .m_axis_tvalid    (m_valid),
    .m_axis_tready    (m_ready),
    .m_axis_tdata     (m_data),
    .m_axis_tlast     (m_last),
    .m_axis_tid       (m_tid),
    .m_axis_tdest     (m_dest),
    .o_overflow       (ovf),
    .i_overflow_clr   (ovf_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (arst_n && m_valid && m_ready) begin
      q_data.push_back(m_data);
      q_last.push_back(m_last);
      q_tid.push_back(m_tid);
      q_dest.push_back(m_dest);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_q();
    q_data.delete();
    q_last.delete();
    q_tid.delete();
    q_dest.delete();
    q_cyc.delete();
  endtask

  task automatic set_word(input int ch, input logic [31:0] d,
                          input logic l);
    tvalid[ch]        = 1'b1;
    tdata[32*ch +: 32] = d;
    tlast[ch]         = l;
  endtask

  task automatic clr_in();
    tvalid = '0;
    tlast  = '0;
  endtask

  task automatic do_reset();
    arst_n  = 1'b0;
    clr_in();
    m_ready = 1'b1;
    ovf_clr = 1'b0;
    en      = '1;
    for (int i = 0; i < 16; i++) dst[4*i +: 4] = 4'(15 - i);
    tick();
    tick();
    arst_n = 1'b1;
    tick();
    clr_q();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) dst[4*i +: 4] = 4'(15 - i);
    tick();
    tick();
    n_tests++;
    if (m_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_tvalid got %b want 0", m_valid);
    end
    n_tests++;
    if (m_data !== 32'h0) begin
      n_fail++; $display("FAIL rst_tdata got %h want 0", m_data);
    end
    n_tests++;
    if (m_last !== 1'b0) begin
      n_fail++; $display("FAIL rst_tlast got %b want 0", m_last);
    end
    n_tests++;
    if (m_tid !== 4'h0) begin
      n_fail++; $display("FAIL rst_tid got %h want 0", m_tid);
    end
    n_tests++;
    if (m_dest !== 4'h0) begin
      n_fail++; $display("FAIL rst_tdest got %h want 0", m_dest);
    end
    n_tests++;
    if (ovf !== 16'h0) begin
      n_fail++; $display("FAIL rst_ovf got %h want 0", ovf);
    end
    arst_n = 1'b1;
    tick();
  endtask

  // Channel 0 frame of 8; dest changes mid-frame but must not leak.
  task automatic test_single_frame();
    int c0;
    do_reset();
    c0 = cyc;
    for (int w = 0; w < 8; w++) begin
      clr_in();
      set_word(0, 32'hA000_0010 + w, w == 7);
      if (w == 4) dst[3:0] = 4'h0;
      tick();
    end
    clr_in();
    repeat (6) tick();
    dst[3:0] = 4'hF;
    n_tests++;
    if (q_data.size() !== 8) begin
      n_fail++;
      $display("FAIL single_count got %0d want 8", q_data.size());
    end
    for (int i = 0; i < 8; i++) begin
      if (i < q_data.size()) begin
        n_tests++;
        if ({q_tid[i], q_data[i], q_last[i], q_dest[i]} !==
            {4'h0, 32'hA000_0010 + i, i == 7, 4'hF} ||
            q_cyc[i] !== c0 + 2 + i) begin
          n_fail++;
          $display("FAIL single_beat%0d got tid=%h d=%h l=%b dst=%h c=%0d want tid=0 d=%h l=%b dst=f c=%0d",
                   i, q_tid[i], q_data[i], q_last[i], q_dest[i],
                   q_cyc[i], 32'hA000_0010 + i, i == 7, c0 + 2 + i);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]  e_tid  [4] = '{4'd3, 4'd3, 4'd5, 4'd5};
    logic [31:0] e_data [4] = '{32'h3000_0000, 32'h3000_0001,
                                32'h5000_0000, 32'h5000_0001};
    logic        e_last [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0]  e_dest [4] = '{4'd12, 4'd12, 4'd10, 4'd10};
    do_reset();
    for (int w = 0; w < 2; w++) begin
      clr_in();
      set_word(3, 32'h3000_0000 + w, w == 1);
      set_word(5, 32'h5000_0000 + w, w == 1);
      tick();
    end
    clr_in();
    repeat (8) tick();
    n_tests++;
    if (q_data.size() !== 4) begin
      n_fail++; $display("FAIL rr_count got %0d want 4", q_data.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < q_data.size()) begin
        n_tests++;
        if ({q_tid[i], q_data[i], q_last[i], q_dest[i]} !==
            {e_tid[i], e_data[i], e_last[i], e_dest[i]}) begin
          n_fail++;
          $display("FAIL rr_beat%0d got tid=%h d=%h l=%b dst=%h want tid=%h d=%h l=%b dst=%h",
                   i, q_tid[i], q_data[i], q_last[i], q_dest[i],
                   e_tid[i], e_data[i], e_last[i], e_dest[i]);
        end
      end
    end
  endtask

  // The output register takes word 0; the FIFO then holds words 1..4.
  task automatic test_overflow();
    do_reset();
    m_ready = 1'b0;
    for (int w = 0; w < 6; w++) begin
      clr_in();
      set_word(2, 32'hB000_0000 + w, 1'b0);
      tick();
    end
    clr_in();
    tick();
    n_tests++;
    if (ovf !== 16'h0004) begin
      n_fail++; $display("FAIL ovf_flag got %h want 0004", ovf);
    end
    repeat (3) tick();
    n_tests++;
    if ({m_valid, m_data, m_tid} !== {1'b1, 32'hB000_0000, 4'd2}) begin
      n_fail++;
      $display("FAIL ovf_hold got v=%b d=%h tid=%h want v=1 d=b0000000 tid=2",
               m_valid, m_data, m_tid);
    end
    m_ready = 1'b1;
    repeat (10) tick();
    n_tests++;
    if (q_data.size() !== 5) begin
      n_fail++; $display("FAIL ovf_count got %0d want 5", q_data.size());
    end
    for (int i = 0; i < 5; i++) begin
      if (i < q_data.size()) begin
        n_tests++;
        if ({q_tid[i], q_data[i]} !== {4'd2, 32'hB000_0000 + i}) begin
          n_fail++;
          $display("FAIL ovf_beat%0d got tid=%h d=%h want tid=2 d=%h",
                   i, q_tid[i], q_data[i], 32'hB000_0000 + i);
        end
      end
    end
  endtask

  task automatic test_disable();
    do_reset();
    set_word(1, 32'hC100_0000, 1'b0);
    set_word(4, 32'hC400_0000, 1'b1);
    tick();
    clr_in();
    set_word(1, 32'hC100_0001, 1'b0);
    tick();
    en[1] = 1'b0;
    set_word(1, 32'hC100_0002, 1'b0);
    tick();
    set_word(1, 32'hC100_0003, 1'b1);
    tick();
    clr_in();
    repeat (6) tick();
    n_tests++;
    if (q_data.size() !== 2) begin
      n_fail++; $display("FAIL dis_count got %0d want 2", q_data.size());
    end
    if (q_data.size() > 0) begin
      n_tests++;
      if ({q_tid[0], q_data[0], q_last[0], q_dest[0]} !==
          {4'd1, 32'hC100_0000, 1'b0, 4'd14}) begin
        n_fail++;
        $display("FAIL dis_beat0 got tid=%h d=%h l=%b dst=%h want tid=1 d=c1000000 l=0 dst=e",
                 q_tid[0], q_data[0], q_last[0], q_dest[0]);
      end
    end
    if (q_data.size() > 1) begin
      n_tests++;
      if ({q_tid[1], q_data[1], q_last[1], q_dest[1]} !==
          {4'd4, 32'hC400_0000, 1'b1, 4'd11}) begin
        n_fail++;
        $display("FAIL dis_beat1 got tid=%h d=%h l=%b dst=%h want tid=4 d=c4000000 l=1 dst=b",
                 q_tid[1], q_data[1], q_last[1], q_dest[1]);
      end
    end
    n_tests++;
    if (ovf !== 16'h0) begin
      n_fail++; $display("FAIL dis_ovf got %h want 0", ovf);
    end
    en[1] = 1'b1;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    m_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      clr_in();
      set_word(6, 32'hD600_0000 + w, 1'b0);
      tick();
    end
    clr_in();
    tick();
    n_tests++;
    if ({m_valid, m_tid, m_dest} !== {1'b1, 4'd6, 4'd9}) begin
      n_fail++;
      $display("FAIL mid_pre got v=%b tid=%h dst=%h want v=1 tid=6 dst=9",
               m_valid, m_tid, m_dest);
    end
    arst_n = 1'b0;
    #1;
    n_tests++;
    if ({m_valid, m_data, m_last, m_tid, m_dest} !== 41'h0) begin
      n_fail++;
      $display("FAIL mid_rst got v=%b d=%h l=%b tid=%h dst=%h want all 0",
               m_valid, m_data, m_last, m_tid, m_dest);
    end
    tick();
    arst_n  = 1'b1;
    m_ready = 1'b1;
    clr_q();
    repeat (8) tick();
    n_tests++;
    if (q_data.size() !== 0) begin
      n_fail++; $display("FAIL mid_quiet got %0d beats want 0", q_data.size());
    end
    set_word(6, 32'hD600_00FF, 1'b1);
    tick();
    clr_in();
    repeat (4) tick();
    n_tests++;
    if (q_data.size() !== 1 || q_data[0] !== 32'hD600_00FF) begin
      n_fail++;
      $display("FAIL mid_new got %0d beats want 1 of d60000ff", q_data.size());
    end
  endtask

  task automatic test_overflow_clr();
    do_reset();
    m_ready = 1'b0;
    for (int w = 0; w < 6; w++) begin
      clr_in();
      set_word(7, 32'hE700_0000 + w, 1'b0);
      set_word(9, 32'hE900_0000 + w, 1'b0);
      tick();
    end
    clr_in();
    n_tests++;
    if (ovf !== 16'h0280) begin
      n_fail++; $display("FAIL clr_pre got %h want 0280", ovf);
    end
    ovf_clr = 1'b1;
    set_word(7, 32'hE700_00AA, 1'b0);
    tick();
    ovf_clr = 1'b0;
    clr_in();
    n_tests++;
    if (ovf !== 16'h0080) begin
      n_fail++; $display("FAIL clr_win got %h want 0080", ovf);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_tests++;
    if (ovf !== 16'h0000) begin
      n_fail++; $display("FAIL clr_all got %h want 0000", ovf);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_overflow();
    test_disable();
    test_reset_midframe();
    test_overflow_clr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
